uart_tx_mmio: RTL
=================

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 Parameter BASE_ADDR, default 16'hFF00: data-bus base address of the register window.
REQ-002 Parameter CLK_DIV, default 434: reset value of the DIVISOR register, in clk cycles per bit.
REQ-003 Parameter FIFO_DEPTH, default 16: number of TX FIFO byte entries; it SHALL be a power of two.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port busAddress, input, 16: data address from the CPU.
REQ-007 Port busWrData, input, 32: CPU store data.
REQ-008 Port busWrEn, input, 1: CPU write enable; it is level-held by the CPU after a store.
REQ-009 Port busRdData, output, 32: read data to the CPU.
REQ-010 Port txd, output, 1: serial line, 8N1, LSB first, idle high.

Function
REQ-011 Registers at BASE_ADDR offsets:
- +0 TXDATA: a write pushes busWrData[7:0]; reads return 0.
- +1 STATUS: read-only; bit0 full, bit1 empty, bit2 busy, bits[12:8] FIFO level.
- +2 DIVISOR: read/write, 16 bits.
REQ-012 busRdData SHALL be combinational from busAddress and registered state, with zero-cycle latency; addresses outside the window return 32'h0.
REQ-013 A write event occurs only in a cycle where busWrEn=1 and {busAddress, busWrData} differs from the previous cycle's value, or busWrEn was 0 in the previous cycle; a held busWrEn SHALL NOT repeat a push.
REQ-014 A TXDATA write event while the FIFO is full and no pop occurs in the same cycle SHALL be dropped; the FIFO contents are unchanged.
REQ-015 A simultaneous push and pop with the FIFO full SHALL accept the push; the level is unchanged.
REQ-016 The FSM states are IDLE, START, DATA, STOP.
- IDLE with FIFO non-empty: pop the head, latch DIVISOR, go to START on the same edge.
REQ-017 Each state holds txd for the latched divisor count of cycles.
- START drives 0.
- DATA drives bits 0..7 via a 3-bit index.
- STOP drives 1, then returns to IDLE; if the FIFO is non-empty at that edge, it pops back-to-back with no idle gap.
REQ-018 A DIVISOR value of 0 or 1 SHALL be treated as 2; a write mid-frame takes effect at the next frame start.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 With the FIFO empty and FSM idle, a push at edge N SHALL produce a pop at edge N+1 and txd=0 from edge N+1.
REQ-021 A frame SHALL last exactly 10 x divisor cycles.

Reset
REQ-022 While rst=1 at an edge, the block SHALL set:
- FSM to IDLE and txd to 1;
- the FIFO empty, with its pointers at 0;
- DIVISOR to CLK_DIV;
- the write-event history to "busWrEn was 0".
REQ-023 Reset mid-frame SHALL abort the frame; txd=1 from the reset edge and no partial byte is resumed.

Configuration
REQ-024 Macro UART_TX_OVF_CNT_EN defined: register +3 OVFCNT holds a 16-bit count of dropped pushes; it saturates at 16'hFFFF, reads as zero-extended, any write event clears it, and reset clears it.
REQ-025 Macro UART_TX_OVF_CNT_EN undefined: no counter logic; offset +3 reads 0 and ignores writes.

Structure
REQ-026 Package uart_tx_pkg SHALL hold the register offsets, STATUS bit positions and the FSM state enum.
REQ-027 The FIFO SHALL be a separate sub-module, sync_fifo, with parameters WIDTH=8 and DEPTH.
- Ports: push, pop, data in/out, full, empty, level.
- Pointers one bit wider than the index.

Verification
REQ-028 Reset; write 8'h55 to FF00 with DIVISOR=4 -> txd low 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), high 4; busy=1 for 40 cycles.
REQ-029 busWrEn held 5 cycles at FF00 with data 8'h41 -> exactly one push; STATUS level=1 after one cycle.
REQ-030 17 distinct pushes with DIVISOR=100 while byte 0 transmits -> 16 accepted; full=1; OVFCNT=1 if UART_TX_OVF_CNT_EN, else a read of FF03 returns 0.
REQ-031 Write DIVISOR=1 -> read FF02 returns 1; frame bits last 2 cycles each.
REQ-032 Assert rst during the DATA state of byte 8'hF0 -> txd=1 next cycle; STATUS reads empty=1, busy=0, level=0; no further edges on txd.
REQ-033 Two bytes queued -> STOP of byte 1 is followed immediately by START of byte 2 with no idle cycle.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Register map, STATUS bit positions and transmitter state encodings shared by the UART TX block.
package uart_tx_pkg;

  localparam logic [15:0] OFF_TXDATA  = 16'd0;
  localparam logic [15:0] OFF_STATUS  = 16'd1;
  localparam logic [15:0] OFF_DIVISOR = 16'd2;
  localparam logic [15:0] OFF_OVFCNT  = 16'd3;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_LVL_LSB = 8;

  typedef logic [1:0] tx_state_t;
  localparam tx_state_t S_IDLE  = 2'd0;
  localparam tx_state_t S_START = 2'd1;
  localparam tx_state_t S_DATA  = 2'd2;
  localparam tx_state_t S_STOP  = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; push visible at rd_dat one cycle later.
// A push while full is accepted only if a pop frees the slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    level    = wr_ptr_q - rd_ptr_q;
    rd_dat   = mem_q[rd_ptr_q[AW-1:0]];
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter; zero-latency reads, frame starts one cycle after push, full FIFO drops pushes.
// Define UART_TX_OVF_CNT_EN to add the dropped-push counter at offset +3.
module uart_tx_mmio
  import uart_tx_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] busAddress,
  input  logic [31:0] busWrData,
  input  logic        busWrEn,
  output logic [31:0] busRdData,
  output logic        txd
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic            prev_en_q, prev_en_d;
  logic [15:0]     prev_addr_q, prev_addr_d;
  logic [31:0]     prev_dat_q, prev_dat_d;
  logic [15:0]     div_q, div_d;
  tx_state_t       state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     lat_div_q, lat_div_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      byte_q, byte_d;
  logic            txd_q, txd_d;

  logic [15:0]     off;
  logic            wr_evt, period_end, start_frame;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_rd_dat;
  logic [LW-1:0]   fifo_level;
  logic [31:0]     status;
  logic [31:0]     ovf_rd;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (fifo_push),
    .wr_dat (busWrData[7:0]),
    .pop    (fifo_pop),
    .rd_dat (fifo_rd_dat),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // A held store only counts once: it must differ from last cycle's bus value.
  always_comb begin
    off         = busAddress - BASE_ADDR;
    wr_evt      = busWrEn && (!prev_en_q || ({busAddress, busWrData} != {prev_addr_q, prev_dat_q}));
    fifo_push   = wr_evt && (off == OFF_TXDATA);
    prev_en_d   = busWrEn;
    prev_addr_d = busAddress;
    prev_dat_d  = busWrData;
    div_d       = (wr_evt && (off == OFF_DIVISOR)) ? busWrData[15:0] : div_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_div_d   = lat_div_q;
    bit_idx_d   = bit_idx_q;
    byte_d      = byte_q;
    txd_d       = txd_q;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;
    period_end  = (cnt_q == lat_div_q - 16'd1);
    if (state_q != S_IDLE) cnt_d = period_end ? 16'd0 : cnt_q + 16'd1;
    case (state_q)
      S_IDLE: begin
        txd_d       = 1'b1;
        start_frame = !fifo_empty;
      end
      S_START: if (period_end) begin
        state_d   = S_DATA;
        bit_idx_d = 3'd0;
        txd_d     = byte_q[0];
      end
      S_DATA: if (period_end) begin
        if (bit_idx_q == 3'd7) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end else begin
          bit_idx_d = bit_idx_q + 3'd1;
          txd_d     = byte_q[bit_idx_q + 3'd1];
        end
      end
      S_STOP: if (period_end) begin
        state_d     = S_IDLE;
        txd_d       = 1'b1;
        start_frame = !fifo_empty;
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
    // Divisors below 2 are clamped; the value is frozen for the whole frame.
    if (start_frame) begin
      fifo_pop  = 1'b1;
      byte_d    = fifo_rd_dat;
      lat_div_d = (div_q < 16'd2) ? 16'd2 : div_q;
      cnt_d     = 16'd0;
      state_d   = S_START;
      txd_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_en_q   <= 1'b0;
      prev_addr_q <= '0;
      prev_dat_q  <= '0;
      div_q       <= 16'(CLK_DIV);
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lat_div_q   <= 16'd2;
      bit_idx_q   <= '0;
      byte_q      <= '0;
      txd_q       <= 1'b1;
    end else begin
      prev_en_q   <= prev_en_d;
      prev_addr_q <= prev_addr_d;
      prev_dat_q  <= prev_dat_d;
      div_q       <= div_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_div_q   <= lat_div_d;
      bit_idx_q   <= bit_idx_d;
      byte_q      <= byte_d;
      txd_q       <= txd_d;
    end
  end

`ifdef UART_TX_OVF_CNT_EN
  logic [15:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (wr_evt && (off == OFF_OVFCNT)) ovf_d = 16'd0;
    else if (fifo_push && fifo_full && !fifo_pop && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
    ovf_rd = {16'h0, ovf_q};
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= ovf_d;
  end
`else
  always_comb ovf_rd = 32'h0;
`endif

  always_comb begin
    status                      = '0;
    status[ST_FULL]             = fifo_full;
    status[ST_EMPTY]            = fifo_empty;
    status[ST_BUSY]             = (state_q != S_IDLE);
    status[ST_LVL_LSB +: LW]    = fifo_level;
    case (off)
      OFF_STATUS:  busRdData = status;
      OFF_DIVISOR: busRdData = {16'h0, div_q};
      OFF_OVFCNT:  busRdData = ovf_rd;
      default:     busRdData = 32'h0;
    endcase
    txd = txd_q;
  end

endmodule
